// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with a busy-register scoreboard.
// Decode reads NREAD combinational ports and gets per-port hazard flags;
// writeback writes one result per cycle with optional same-cycle forwarding.

// One read port: selects stored/forwarded data and the hazard flag.
module regfile_mp_rport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][XLEN-1:0] rf,
  input  logic [NREGS-1:0]           busy,
  input  logic                       we,
  input  logic                       wr_ok,
  input  logic [AW-1:0]              waddr,
  input  logic [XLEN-1:0]            wdata,
  input  logic [AW-1:0]              raddr,
  output logic [XLEN-1:0]            rdata,
  output logic                       rbusy
);
  localparam logic [AW:0] NR = (AW+1)'(NREGS);

  logic rd_ok;
  logic hit;

  assign rd_ok = ({1'b0, raddr} < NR) && !((ZERO_REG != 0) && (raddr == '0));
  assign hit   = (BYPASS != 0) && we && (waddr == raddr);

  // Port mux: out-of-range and hardwired-zero reads return 0; a matching
  // write this cycle is forwarded and also resolves the hazard.
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (rd_ok) begin
      rdata = (hit && wr_ok) ? wdata : rf[raddr];
      rbusy = busy[raddr] & ~hit;
    end
  end
endmodule

// Top: storage, scoreboard and an array of read ports.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  output logic [NREAD-1:0]      rbusy,
  input  logic                  issue_en,
  input  logic [AW-1:0]         issue_rd,
  input  logic                  flush,
  output logic [AW:0]           busy_cnt
);
  localparam logic [AW:0] NR = (AW+1)'(NREGS);

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_req_t;

  wr_req_t                     wr;
  logic [NREGS-1:0][XLEN-1:0]  rf;
  logic [NREGS-1:0]            busy, busy_nxt;
  logic [AW:0]                 cnt_nxt;
  logic [NREAD-1:0][AW-1:0]    ra;
  logic [NREAD-1:0][XLEN-1:0]  rd;
  logic                        wa_rng, wr_ok, set_ok;

  assign wr     = '{en: we, addr: waddr, data: wdata};
  assign ra     = raddr;
  assign rdata  = rd;
  assign wa_rng = {1'b0, wr.addr} < NR;
  assign wr_ok  = wr.en && wa_rng && !((ZERO_REG != 0) && (wr.addr == '0));
  assign set_ok = issue_en && ({1'b0, issue_rd} < NR) &&
                  !((ZERO_REG != 0) && (issue_rd == '0));

  // Register array write; out-of-range and r0 writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rf <= '0;
    else if (wr_ok) rf[wr.addr] <= wr.data;
  end

  // Next busy vector: writeback clears, issue sets (younger wins), flush clears all.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr.en && wa_rng) busy_nxt[wr.addr] = 1'b0;
      if (set_ok)          busy_nxt[issue_rd] = 1'b1;
    end
  end

  // Population count of the next busy vector so busy_cnt tracks the bits exactly.
  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++) cnt_nxt = cnt_nxt + {{AW{1'b0}}, busy_nxt[r]};
  end

  // Scoreboard state and its registered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    regfile_mp_rport #(
      .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rport (
      .rf(rf), .busy(busy), .we(wr.en), .wr_ok(wr_ok), .waddr(wr.addr),
      .wdata(wr.data), .raddr(ra[i]), .rdata(rd[i]), .rbusy(rbusy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: three DUT configurations share one stimulus stream;
// an array-based reference model queues expectations, a negedge monitor checks.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [2:0][4:0] ra = '0;
  logic        issue_en = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        flush = 1'b0;

  logic [63:0]  rdata_a, rdata_b;
  logic [191:0] rdata_c;
  logic [1:0]   rbusy_a, rbusy_b;
  logic [2:0]   rbusy_c;
  logic [5:0]   cnt_a, cnt_b, cnt_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata[31:0]),
    .raddr({ra[1], ra[0]}), .rdata(rdata_a), .rbusy(rbusy_a),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .busy_cnt(cnt_a));

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata[31:0]),
    .raddr({ra[1], ra[0]}), .rdata(rdata_b), .rbusy(rbusy_b),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .busy_cnt(cnt_b));

  regfile_mp #(.XLEN(64), .NREGS(24), .NREAD(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr({ra[2], ra[1], ra[0]}), .rdata(rdata_c), .rbusy(rbusy_c),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .busy_cnt(cnt_c));

  // Reference model: plain arrays per configuration.
  int          nr[3]  = '{32, 32, 24};
  int          byp[3] = '{1, 0, 1};
  int          np[3]  = '{2, 2, 3};
  logic [63:0] msk[3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] m_rf[3][32];
  bit          m_bz[3][32];

  typedef struct {
    int          d;
    logic [63:0] rd[3];
    logic [2:0]  rb;
    logic [5:0]  cnt;
    string       tag;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] m_read(input int d, input int a);
    if (a >= nr[d] || a == 0) return 64'd0;
    if (byp[d] != 0 && we && int'(waddr) == a) return wdata & msk[d];
    return m_rf[d][a];
  endfunction

  function automatic bit m_busy(input int d, input int a);
    if (a >= nr[d] || a == 0) return 1'b0;
    if (byp[d] != 0 && we && int'(waddr) == a) return 1'b0;
    return m_bz[d][a];
  endfunction

  function automatic int m_cnt(input int d);
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(m_bz[d][r]);
    return c;
  endfunction

  task automatic m_clear();
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 32; r++) begin
        m_rf[d][r] = '0;
        m_bz[d][r] = 1'b0;
      end
  endtask

  // One cycle of stimulus: drive, queue expected outputs, advance the model.
  task automatic cyc(input bit r, input bit w, input int wa, input logic [63:0] wd,
                     input bit is, input int rd, input bit fl,
                     input int a0, input int a1, input int a2, input string tag);
    exp_t e;
    int   a[3];
    @(posedge clk);
    #1;
    rst_n = r; we = w; waddr = wa[4:0]; wdata = wd;
    issue_en = is; issue_rd = rd[4:0]; flush = fl;
    ra[0] = a0[4:0]; ra[1] = a1[4:0]; ra[2] = a2[4:0];
    a = '{a0, a1, a2};
    if (!r) m_clear();
    for (int d = 0; d < 3; d++) begin
      e.d = d; e.tag = tag; e.rb = '0;
      for (int p = 0; p < 3; p++) begin
        e.rd[p] = (p < np[d]) ? m_read(d, a[p]) : 64'd0;
        e.rb[p] = (p < np[d]) ? m_busy(d, a[p]) : 1'b0;
      end
      e.cnt = 6'(m_cnt(d));
      q.push_back(e);
    end
    if (r) begin
      for (int d = 0; d < 3; d++) begin
        if (w && wa < nr[d] && wa != 0) m_rf[d][wa] = wd & msk[d];
        if (fl) begin
          for (int k = 0; k < 32; k++) m_bz[d][k] = 1'b0;
        end else begin
          if (w && wa < nr[d]) m_bz[d][wa] = 1'b0;
          if (is && rd < nr[d] && rd != 0) m_bz[d][rd] = 1'b1;
        end
      end
    end
  endtask

  // Monitor: outputs are settled mid-cycle; compare against queued expectations.
  initial begin
    exp_t        e;
    logic [63:0] act;
    logic        ab;
    logic [5:0]  ac;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        for (int p = 0; p < np[e.d]; p++) begin
          case (e.d)
            0:       begin act = {32'd0, rdata_a[p*32 +: 32]}; ab = rbusy_a[p]; end
            1:       begin act = {32'd0, rdata_b[p*32 +: 32]}; ab = rbusy_b[p]; end
            default: begin act = rdata_c[p*64 +: 64];          ab = rbusy_c[p]; end
          endcase
          check($sformatf("%s.dut%0d.rdata%0d", e.tag, e.d, p), act, e.rd[p]);
          check($sformatf("%s.dut%0d.rbusy%0d", e.tag, e.d, p), {63'd0, ab}, {63'd0, e.rb[p]});
        end
        ac = (e.d == 0) ? cnt_a : (e.d == 1) ? cnt_b : cnt_c;
        check($sformatf("%s.dut%0d.busy_cnt", e.tag, e.d), {58'd0, ac}, {58'd0, e.cnt});
      end
    end
  end

  initial begin
    m_clear();
    //  r  w  wa  wdata                   is rd  fl a0  a1  a2  tag
    cyc(0, 0, 0,  64'd0,                  0, 0,  0, 5,  7,  3,  "in_reset");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 5,  7,  3,  "idle");
    cyc(1, 1, 5,  64'hDEADBEEF,           1, 5,  0, 5,  5,  5,  "wr5");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 5,  5,  5,  "rd5");
    cyc(0, 0, 0,  64'd0,                  0, 0,  0, 5,  5,  5,  "rst_mid");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 5,  5,  5,  "release");
    cyc(1, 1, 0,  64'h1234,               0, 0,  0, 0,  0,  0,  "wr0");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 0,  0,  0,  "rd0");
    cyc(1, 1, 7,  64'hA5A5A5A5,           0, 0,  0, 7,  7,  7,  "wr7");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 7,  7,  7,  "rd7");
    cyc(1, 0, 0,  64'd0,                  1, 3,  0, 3,  3,  3,  "iss3");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 3,  3,  3,  "busy3");
    cyc(1, 1, 3,  64'h33,                 0, 0,  0, 3,  3,  3,  "wb3");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 3,  3,  3,  "clr3");
    cyc(1, 0, 0,  64'd0,                  1, 9,  0, 9,  9,  9,  "iss9");
    cyc(1, 1, 9,  64'h99,                 1, 9,  0, 9,  9,  9,  "sim9");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 9,  9,  9,  "still9");
    cyc(1, 0, 0,  64'd0,                  1, 0,  0, 0,  9,  0,  "iss0");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 0,  9,  0,  "after0");
    cyc(1, 0, 0,  64'd0,                  1, 1,  0, 1,  2,  31, "iss1");
    cyc(1, 0, 0,  64'd0,                  1, 2,  0, 1,  2,  31, "iss2");
    cyc(1, 0, 0,  64'd0,                  1, 31, 0, 1,  2,  31, "iss31");
    cyc(1, 1, 2,  64'h22,                 1, 4,  1, 2,  4,  31, "flush");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 2,  4,  31, "post_flush");
    cyc(1, 1, 30, 64'hCAFE_F00D_1234_5678, 1, 30, 0, 30, 30, 30, "wr30");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 30, 30, 30, "rd30");
    cyc(1, 1, 23, 64'hFEED_0000_0000_0023, 0, 0,  0, 23, 23, 23, "wr23");
    cyc(1, 0, 0,  64'd0,                  0, 0,  0, 23, 23, 23, "rd23");

    for (int n = 0; n < 400; n++) begin
      bit r;
      r = ($urandom_range(0, 99) != 0);
      cyc(r, r ? 1'($urandom_range(0, 1)) : 1'b0, int'($urandom_range(0, 31)),
          {$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
          ($urandom_range(0, 19) == 0), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), "rand");
    end

    @(negedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
